// File: rtl/servo_frame_pkg.sv
// Shared constants and state encoding for the servo frame scheduler.
package servo_frame_pkg;
    localparam logic [7:0] HDR_BYTE   = 8'h55;
    localparam int         LEN_OFFSET = 3;
    localparam int         HDR_BYTES  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from last_grant+1, wrapping, and returns
// a one-hot grant with its binary index.
module rr_arbiter
    import servo_frame_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last_grant,
    input  logic            grant_en,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      grant_idx
);

    always_comb begin
        logic found;
        int   idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && grant_en && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_servo_frame_sched.sv
// Shares one uart_byte_tx among NREQ requesters: round-robin grant, then streams
// 55 55 ID LEN CMD params checksum through the send_en/tx_done handshake.
module uart_servo_frame_sched
    import servo_frame_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_PARAM = 4,
    parameter int TIMEOUT   = 100000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [8*NREQ-1:0]         req_id,
    input  logic [8*NREQ-1:0]         req_cmd,
    input  logic [3*NREQ-1:0]         req_nparam,
    input  logic [8*MAX_PARAM*NREQ-1:0] req_param,
    output logic [NREQ-1:0]           req_ready,
    output logic [7:0]                tx_data,
    output logic                      tx_send_en,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      timeout_err,
    output logic [2:0]                grant_idx
);

    localparam int PW    = 8 * MAX_PARAM;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state, state_nxt;
    logic             armed;
    logic [2:0]       last_grant;
    logic [NREQ-1:0]  grant;
    logic [2:0]       win_idx;
    logic [2:0]       win_np;
    logic [2:0]       win_n;
    logic [7:0]       id_q, cmd_q;
    logic [2:0]       n_q;
    logic [PW-1:0]    par_q;
    logic [3:0]       byte_idx, nxt_idx;
    logic [7:0]       nxt_byte;
    logic [7:0]       chk_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_byte, expire, accept;

    // armed keeps req_ready low while reset is held, even with requests pending
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant_en   (armed && (state == ST_IDLE)),
        .grant      (grant),
        .grant_idx  (win_idx)
    );

    assign accept     = |grant;
    assign req_ready  = grant;
    assign tx_send_en = (state == ST_SEND);
    assign busy       = (state != ST_IDLE);
    assign last_byte  = (byte_idx == ({1'b0, n_q} + 4'd5));
    assign expire     = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign nxt_idx    = byte_idx + 4'd1;

    always_comb begin
        win_np = req_nparam[3*int'(win_idx) +: 3];
        win_n  = (int'(win_np) > MAX_PARAM) ? 3'(MAX_PARAM) : win_np;
    end

    // Byte following byte_idx; the default is the checksum, overridden for earlier slots
    always_comb begin
        nxt_byte = ~chk_q;
        if (nxt_idx < 4'(HDR_BYTES)) begin
            nxt_byte = HDR_BYTE;
        end else if (nxt_idx == 4'd2) begin
            nxt_byte = id_q;
        end else if (nxt_idx == 4'd3) begin
            nxt_byte = {5'd0, n_q} + 8'(LEN_OFFSET);
        end else if (nxt_idx == 4'd4) begin
            nxt_byte = cmd_q;
        end else begin
            for (int k = 0; k < MAX_PARAM; k++) begin
                if ((nxt_idx == 4'(5 + k)) && (k < int'(n_q))) begin
                    nxt_byte = par_q[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_SEND;
            ST_SEND: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    state_nxt = last_byte ? ST_IDLE : ST_SEND;
                end else if (expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            armed       <= 1'b0;
            last_grant  <= 3'(NREQ - 1);
            grant_idx   <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            tx_data     <= '0;
            byte_idx    <= '0;
            chk_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state       <= state_nxt;
            armed       <= 1'b1;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        last_grant <= win_idx;
                        grant_idx  <= win_idx;
                        byte_idx   <= '0;
                        chk_q      <= '0;
                        tx_data    <= HDR_BYTE;
                    end
                end
                ST_SEND: cnt_q <= '0;
                ST_WAIT: begin
                    if (tx_done) begin
                        if (last_byte) begin
                            frame_done <= 1'b1;
                        end else begin
                            byte_idx <= nxt_idx;
                            tx_data  <= nxt_byte;
                            // checksum covers ID through the last parameter
                            if ((nxt_idx >= 4'(HDR_BYTES)) && (nxt_idx <= ({1'b0, n_q} + 4'd4))) begin
                                chk_q <= chk_q + nxt_byte;
                            end
                        end
                    end else if (expire) begin
                        timeout_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame fields are captured at accept and held for the whole frame
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && accept) begin
            id_q  <= req_id[8*int'(win_idx) +: 8];
            cmd_q <= req_cmd[8*int'(win_idx) +: 8];
            n_q   <= win_n;
            par_q <= req_param[PW*int'(win_idx) +: PW];
        end
    end

endmodule
